// File: rtl/semaphore_phase_ctrl.sv
// Two-road traffic-light sequencer with an optional pedestrian phase.
// Phase lengths are counted in ticks of an external timer, which is driven through a start/done handshake.
module semaphore_phase_ctrl #(
  parameter int NS_GREEN_TICKS   = 4,
  parameter int EW_GREEN_TICKS   = 4,
  parameter int YELLOW_TICKS     = 1,
  parameter int RED_YELLOW_TICKS = 1,
  parameter int ALL_RED_TICKS    = 1,
  parameter int PED_TICKS        = 3,
  parameter int TW               = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       tmr_done,
  output logic       tmr_start,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    S_NS_GREEN      = 4'd0,
    S_NS_YELLOW     = 4'd1,
    S_ALL_RED_1     = 4'd2,
    S_EW_RED_YELLOW = 4'd3,
    S_EW_GREEN      = 4'd4,
    S_EW_YELLOW     = 4'd5,
    S_ALL_RED_2     = 4'd6,
    S_NS_RED_YELLOW = 4'd7,
    S_PED_WALK      = 4'd8,
    S_FLASH         = 4'd9
  } state_e;

  localparam logic [TW-1:0] NS_GREEN_LAST   = TW'(NS_GREEN_TICKS - 1);
  localparam logic [TW-1:0] EW_GREEN_LAST   = TW'(EW_GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LAST     = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] RED_YELLOW_LAST = TW'(RED_YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALL_RED_LAST    = TW'(ALL_RED_TICKS - 1);
  localparam logic [TW-1:0] PED_LAST        = TW'(PED_TICKS - 1);

  localparam logic [2:0] LAMP_RED        = 3'b100;
  localparam logic [2:0] LAMP_RED_YELLOW = 3'b110;
  localparam logic [2:0] LAMP_YELLOW     = 3'b010;
  localparam logic [2:0] LAMP_GREEN      = 3'b001;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          busy_q, busy_d;
  logic          ped_pending_q, ped_pending_d;
  logic          flash_on_q, flash_on_d;

  logic          tick;
  logic          state_valid;
  logic [TW-1:0] len_last;
  state_e        seq_next;

  // A new timer period is requested whenever none is in flight.
  assign tmr_start   = reset & ~busy_q;
  assign tick        = busy_q & tmr_done;
  assign state_valid = (state_q <= S_FLASH);
  assign phase       = state_q;

  always_comb begin
    len_last = '0;
    case (state_q)
      S_NS_GREEN:                       len_last = NS_GREEN_LAST;
      S_EW_GREEN:                       len_last = EW_GREEN_LAST;
      S_NS_YELLOW, S_EW_YELLOW:         len_last = YELLOW_LAST;
      S_NS_RED_YELLOW, S_EW_RED_YELLOW: len_last = RED_YELLOW_LAST;
      S_ALL_RED_1, S_ALL_RED_2:         len_last = ALL_RED_LAST;
      S_PED_WALK:                       len_last = PED_LAST;
      default:                          len_last = '0;
    endcase
  end

  always_comb begin
    seq_next = S_ALL_RED_2;
    case (state_q)
      S_NS_GREEN:      seq_next = S_NS_YELLOW;
      S_NS_YELLOW:     seq_next = S_ALL_RED_1;
      S_ALL_RED_1:     seq_next = S_EW_RED_YELLOW;
      S_EW_RED_YELLOW: seq_next = S_EW_GREEN;
      S_EW_GREEN:      seq_next = S_EW_YELLOW;
      S_EW_YELLOW:     seq_next = S_ALL_RED_2;
      S_ALL_RED_2:     seq_next = ped_pending_q ? S_PED_WALK : S_NS_RED_YELLOW;
      S_PED_WALK:      seq_next = S_NS_RED_YELLOW;
      S_NS_RED_YELLOW: seq_next = S_NS_GREEN;
      default:         seq_next = S_ALL_RED_2;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    flash_on_d    = flash_on_q;
    busy_d        = busy_q ? ~tmr_done : tmr_start;

    if (state_q == S_FLASH) begin
      if (enable) begin
        state_d    = S_ALL_RED_2;
        tick_cnt_d = '0;
        flash_on_d = 1'b0;
      end else if (tick) begin
        flash_on_d = ~flash_on_q;
      end
    end else if (!enable) begin
      // Maintenance request overrides any tick landing in the same cycle.
      state_d    = S_FLASH;
      tick_cnt_d = '0;
      flash_on_d = 1'b0;
    end else if (!state_valid) begin
      state_d    = S_ALL_RED_2;
      tick_cnt_d = '0;
    end else if (tick) begin
      if (tick_cnt_q == len_last) begin
        state_d    = seq_next;
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end

    ped_pending_d = ped_pending_q | (ped_req & (state_q != S_PED_WALK));
    if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) begin
      ped_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_ALL_RED_2;
      tick_cnt_q    <= '0;
      busy_q        <= 1'b0;
      ped_pending_q <= 1'b0;
      flash_on_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      busy_q        <= busy_d;
      ped_pending_q <= ped_pending_d;
      flash_on_q    <= flash_on_d;
    end
  end

  // Lamp decode is purely from registered state so outputs are glitch-free.
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    ped_walk = 1'b0;
    case (state_q)
      S_NS_GREEN:      ns_light = LAMP_GREEN;
      S_NS_YELLOW:     ns_light = LAMP_YELLOW;
      S_NS_RED_YELLOW: ns_light = LAMP_RED_YELLOW;
      S_EW_GREEN:      ew_light = LAMP_GREEN;
      S_EW_YELLOW:     ew_light = LAMP_YELLOW;
      S_EW_RED_YELLOW: ew_light = LAMP_RED_YELLOW;
      S_PED_WALK:      ped_walk = 1'b1;
      S_FLASH: begin
        ns_light = {1'b0, flash_on_q, 1'b0};
        ew_light = {1'b0, flash_on_q, 1'b0};
      end
      default: begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_semaphore_phase_ctrl.sv
// Directed bench for semaphore_phase_ctrl: a 4-cycle timer model plus per-scenario tasks.
module tb_semaphore_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       ped_req = 1'b0;
  logic       tmr_done = 1'b0;
  logic       tmr_start;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic [3:0] phase;

  int total = 0;
  int bad = 0;
  int tcnt = 0;
  int dones = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  semaphore_phase_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ped_req   (ped_req),
    .tmr_done  (tmr_done),
    .tmr_start (tmr_start),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .ped_walk  (ped_walk),
    .phase     (phase)
  );

  // Expected {ns_light, ew_light} for each normal phase code.
  function automatic logic [5:0] exp_lamps(input int p);
    case (p)
      0: return 6'b001_100;
      1: return 6'b010_100;
      2: return 6'b100_100;
      3: return 6'b100_110;
      4: return 6'b100_001;
      5: return 6'b100_010;
      6: return 6'b100_100;
      7: return 6'b110_100;
      8: return 6'b100_100;
      default: return 6'b000_000;
    endcase
  endfunction

  // One clock cycle with the timer model: done pulses 4 cycles after the start edge.
  task automatic cyc();
    logic st, dn;
    st = tmr_start;
    dn = tmr_done;
    total++;
    if (st === 1'b1 && tcnt != 0) begin
      bad++;
      $display("FAIL start_while_busy: tmr_start=%b want=0 at cycle %0d", st, cyc_no);
    end
    @(posedge clk);
    cyc_no++;
    if (dn && tcnt != 0) dones++;
    if (dn) tcnt = 0;
    if (st) tcnt = 1;
    else if (tcnt > 0) tcnt++;
    @(negedge clk);
    tmr_done = (tcnt == 4);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (phase !== 4'(p) && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (phase !== 4'(p)) begin
      bad++;
      $display("FAIL wait_phase: phase=%0d want=%0d after %0d cycles", phase, p, n);
    end
  endtask

  task automatic wait_dones(input int k, input int budget);
    int target = dones + k;
    int n = 0;
    while (dones < target && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (dones < target) begin
      bad++;
      $display("FAIL wait_dones: dones=%0d want=%0d", dones, target);
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (phase !== 4'd6) begin bad++; $display("FAIL reset_phase: got=%0d want=6", phase); end
    total++; if (ns_light !== 3'b100) begin bad++; $display("FAIL reset_ns: got=%b want=100", ns_light); end
    total++; if (ew_light !== 3'b100) begin bad++; $display("FAIL reset_ew: got=%b want=100", ew_light); end
    total++; if (ped_walk !== 1'b0) begin bad++; $display("FAIL reset_ped: got=%b want=0", ped_walk); end
    total++; if (tmr_start !== 1'b0) begin bad++; $display("FAIL reset_start: got=%b want=0", tmr_start); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (tmr_start !== 1'b1) begin bad++; $display("FAIL release_start: got=%b want=1", tmr_start); end
  endtask

  task automatic test_sequence();
    int exp_seq[8] = '{7, 0, 1, 2, 3, 4, 5, 6};
    int entry[8];
    int idx = 0;
    int n = 0;
    logic [3:0] last;
    last = phase;
    while (idx < 8 && n < 200) begin
      cyc();
      n++;
      if (phase !== last) begin
        entry[idx] = cyc_no;
        total++;
        if (phase !== 4'(exp_seq[idx])) begin
          bad++;
          $display("FAIL seq_phase[%0d]: got=%0d want=%0d", idx, phase, exp_seq[idx]);
        end
        total++;
        if ({ns_light, ew_light} !== exp_lamps(exp_seq[idx])) begin
          bad++;
          $display("FAIL seq_lamps[%0d]: got=%b want=%b", idx, {ns_light, ew_light}, exp_lamps(exp_seq[idx]));
        end
        last = phase;
        idx++;
      end
    end
    total++;
    if (idx != 8) begin
      bad++;
      $display("FAIL seq_timeout: transitions=%0d want=8", idx);
    end else begin
      total++;
      if (entry[2] - entry[1] != 20) begin
        bad++;
        $display("FAIL ns_green_len: got=%0d cycles want=20", entry[2] - entry[1]);
      end
    end
  endtask

  task automatic test_ped_pulse();
    int d0;
    wait_phase(4, 200);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_phase(6, 100);
    wait_phase(8, 10);
    total++; if (ped_walk !== 1'b1) begin bad++; $display("FAIL ped_walk_on: got=%b want=1", ped_walk); end
    total++;
    if ({ns_light, ew_light} !== 6'b100_100) begin
      bad++;
      $display("FAIL ped_lamps: got=%b want=100100", {ns_light, ew_light});
    end
    d0 = dones;
    wait_phase(7, 30);
    total++; if (dones - d0 != 3) begin bad++; $display("FAIL ped_len: got=%0d ticks want=3", dones - d0); end
    total++; if (ped_walk !== 1'b0) begin bad++; $display("FAIL ped_walk_off: got=%b want=0", ped_walk); end
    wait_phase(6, 200);
    wait_phase(7, 10);
  endtask

  task automatic test_spurious();
    int d0;
    wait_phase(0, 20);
    total++; if (tmr_start !== 1'b1) begin bad++; $display("FAIL idle_start: got=%b want=1", tmr_start); end
    d0 = dones;
    tmr_done = 1'b1;
    cyc();
    total++; if (phase !== 4'd0) begin bad++; $display("FAIL spurious_phase: got=%0d want=0", phase); end
    total++;
    if ({ns_light, ew_light} !== 6'b001_100) begin
      bad++;
      $display("FAIL spurious_lamps: got=%b want=001100", {ns_light, ew_light});
    end
    wait_phase(1, 40);
    total++; if (dones - d0 != 4) begin bad++; $display("FAIL spurious_len: got=%0d ticks want=4", dones - d0); end
  endtask

  task automatic test_flash();
    int d2;
    wait_phase(0, 100);
    wait_dones(2, 30);
    total++; if (phase !== 4'd0) begin bad++; $display("FAIL pre_flash_phase: got=%0d want=0", phase); end
    enable = 1'b0;
    cyc();
    total++; if (phase !== 4'd9) begin bad++; $display("FAIL flash_phase: got=%0d want=9", phase); end
    total++;
    if ({ns_light, ew_light, ped_walk} !== 7'b000_000_0) begin
      bad++;
      $display("FAIL flash_off0: got=%b want=0000000", {ns_light, ew_light, ped_walk});
    end
    wait_dones(1, 10);
    total++;
    if ({ns_light, ew_light} !== 6'b010_010) begin
      bad++;
      $display("FAIL flash_on1: got=%b want=010010", {ns_light, ew_light});
    end
    wait_dones(1, 10);
    total++;
    if ({ns_light, ew_light} !== 6'b000_000) begin
      bad++;
      $display("FAIL flash_off1: got=%b want=000000", {ns_light, ew_light});
    end
    total++; if (phase !== 4'd9) begin bad++; $display("FAIL flash_hold: got=%0d want=9", phase); end
    enable = 1'b1;
    cyc();
    total++; if (phase !== 4'd6) begin bad++; $display("FAIL flash_exit: got=%0d want=6", phase); end
    d2 = dones;
    wait_phase(7, 20);
    total++; if (dones - d2 != 1) begin bad++; $display("FAIL flash_exit_len: got=%0d ticks want=1", dones - d2); end
  endtask

  task automatic test_ped_hold();
    wait_phase(4, 100);
    ped_req = 1'b1;
    wait_phase(8, 60);
    total++; if (ped_walk !== 1'b1) begin bad++; $display("FAIL hold_walk: got=%b want=1", ped_walk); end
    wait_phase(7, 30);
    ped_req = 1'b0;
    wait_phase(6, 200);
    wait_phase(7, 10);
    // A fresh press after the walk phase must be honoured on the next lap.
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_phase(6, 200);
    wait_phase(8, 10);
  endtask

  task automatic test_async_reset();
    wait_phase(5, 200);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    cyc();
    #2;
    reset = 1'b0;
    #1;
    tcnt = 0;
    tmr_done = 1'b0;
    total++; if (phase !== 4'd6) begin bad++; $display("FAIL areset_phase: got=%0d want=6", phase); end
    total++;
    if ({ns_light, ew_light} !== 6'b100_100) begin
      bad++;
      $display("FAIL areset_lamps: got=%b want=100100", {ns_light, ew_light});
    end
    total++; if (tmr_start !== 1'b0) begin bad++; $display("FAIL areset_start: got=%b want=0", tmr_start); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (tmr_start !== 1'b1) begin bad++; $display("FAIL arelease_start: got=%b want=1", tmr_start); end
    wait_phase(7, 10);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped_pulse();
    test_spurious();
    test_flash();
    test_ped_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/semaphore_phase_ctrl.md
Name: semaphore_phase_ctrl

Overview:
- Top-level traffic-light sequencer for a two-road crossing (north-south NS, east-west EW) with an optional pedestrian phase.
- Produces no time base itself. It drives one external period timer through a start/done handshake and counts timer expirations ("ticks") to set each phase length.
- Outputs per-direction lamp vectors, a pedestrian walk lamp and the current phase code.

Parameters:
- NS_GREEN_TICKS, 4: ticks spent in NS_GREEN (≥1).
- EW_GREEN_TICKS, 4: ticks spent in EW_GREEN (≥1).
- YELLOW_TICKS, 1: ticks in NS_YELLOW / EW_YELLOW (≥1).
- RED_YELLOW_TICKS, 1: ticks in NS_RED_YELLOW / EW_RED_YELLOW (≥1).
- ALL_RED_TICKS, 1: ticks in ALL_RED_1 / ALL_RED_2 (≥1).
- PED_TICKS, 3: ticks in PED_WALK (≥1).
- TW, 4: tick counter width; must hold max(*_TICKS)-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = normal cycle, 0 = flashing-yellow maintenance mode.
- ped_req  in  1  pedestrian button, level or pulse; sampled every cycle.
- tmr_done  in  1  one-cycle pulse from timer at end of a period.
- tmr_start  out  1  one-cycle pulse starting one timer period.
- ns_light  out  3  {red,yellow,green} for NS.
- ew_light  out  3  {red,yellow,green} for EW.
- ped_walk  out  1  pedestrian walk lamp.
- phase  out  4  current state code.

Behaviour:
- State codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_1=2, EW_RED_YELLOW=3, EW_GREEN=4, EW_YELLOW=5, ALL_RED_2=6, NS_RED_YELLOW=7, PED_WALK=8, FLASH=9. Codes 10-15 are unreachable and recover to ALL_RED_2.
- Reset (reset=0, async):
  - state=ALL_RED_2, tick_cnt=0, busy=0, ped_pending=0, flash_on=0.
  - Outputs: ns_light=3'b100, ew_light=3'b100, ped_walk=0, tmr_start=0, phase=6.
- Timer handshake:
  - Registered busy flag. tmr_start = !busy, combinational, gated by reset released.
  - busy sets on the edge after tmr_start=1 and clears on the edge where tmr_done=1.
  - Hence a new period starts on the cycle after each done, and tmr_start is never asserted while a period is in flight.
  - tmr_done while busy=0 is ignored.
- Tick counting (non-FLASH states), on tmr_done=1 with busy=1:
  - If tick_cnt == LEN(state)-1: advance to the next state and set tick_cnt=0.
  - Otherwise tick_cnt+1.
  - A state therefore lasts exactly LEN ticks.
- Normal sequence: NS_GREEN→NS_YELLOW→ALL_RED_1→EW_RED_YELLOW→EW_GREEN→EW_YELLOW→ALL_RED_2→(PED_WALK if ped_pending)→NS_RED_YELLOW→NS_GREEN.
- Lamps (Moore, decoded from registered state):
  - Green states: 001 on the green direction.
  - Yellow states: 010.
  - Red-yellow states: 110.
  - The other direction is 100 in all of the above, and both directions are 100 in ALL_RED_*/PED_WALK.
  - ped_walk=1 only in PED_WALK.
- Pedestrian request:
  - ped_pending sets on any cycle with ped_req=1 while state≠PED_WALK, and is sticky.
  - It clears on the edge entering PED_WALK; set loses to clear on that same edge.
  - ped_req during PED_WALK is dropped.
- Maintenance mode:
  - enable=0 in any state moves to FLASH on the next edge, regardless of tick_cnt, and clears tick_cnt and flash_on.
  - In FLASH, every accepted tmr_done toggles flash_on. ns_light=ew_light={1'b0,flash_on,1'b0}, ped_walk=0.
  - An in-flight timer period is not aborted; busy still clears on done.
  - enable=1 in FLASH moves to ALL_RED_2 on the next edge with tick_cnt=0.
  - ped_pending is retained through FLASH.
- Simultaneous events: enable=0 wins over a tick-driven transition in the same cycle.

Test Plan:
- Timer model for all tests: done pulses 4 cycles after start. enable=1, no ped, defaults → phase sequence 6,7,0,1,2,3,4,5,6. NS_GREEN lasts exactly 4 ticks = 4×5 cycles (done + restart). tmr_start never high while busy.
- ped_req pulsed once during EW_GREEN → after ALL_RED_2, PED_WALK for 3 ticks with ped_walk=1 and both lights 100. Next ALL_RED_2 goes straight to NS_RED_YELLOW.
- ped_req held high through PED_WALK → no second PED_WALK in the following cycle unless ped_req is reasserted after exiting PED_WALK.
- enable dropped mid NS_GREEN (tick_cnt=2) → phase=9 next cycle. Lights alternate 000/010 per done. enable=1 → phase 6, then 7.
- reset asserted asynchronously mid EW_YELLOW (no clock edge) → outputs immediately 100/100, phase=6, tmr_start=0. After release, tmr_start=1 on the first cycle.
- Spurious tmr_done with busy=0 → no tick counted, state and lamps unchanged.
